// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - state type, line levels and parity helper shared by manchester_tx
package manchester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Line level when nothing is being sent
  localparam logic MAN_IDLE        = 1'b0;
  // IEEE 802.3 convention: a one is low-then-high, a zero is high-then-low
  localparam logic MAN_ONE_FIRST   = 1'b0;
  localparam logic MAN_ONE_SECOND  = 1'b1;
  localparam logic MAN_ZERO_FIRST  = 1'b1;
  localparam logic MAN_ZERO_SECOND = 1'b0;

  // Widest word the parity helper accepts; narrower words are zero-extended
  localparam int PARITY_MAX_W = 64;

  // Line level for one half of a bit cell
  function automatic logic half_level(input logic bit_val, input logic second_half);
    if (bit_val) begin
      return second_half ? MAN_ONE_SECOND : MAN_ONE_FIRST;
    end
    return second_half ? MAN_ZERO_SECOND : MAN_ZERO_FIRST;
  endfunction

  // Even parity bit: makes the total count of ones (word plus parity) even
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/man_bit_timer.sv
// rtl/man_bit_timer.sv - half-bit counter producing half-bit and bit-cell ticks
module man_bit_timer
  import manchester_pkg::*;
#(
  parameter int HALF_PRD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic half_tick,
  output logic bit_tick,
  output logic phase
);

  localparam int CW = ($clog2(HALF_PRD) < 1) ? 1 : $clog2(HALF_PRD);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PRD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // A tick marks the last cycle of a half-bit; restart wins so a fresh frame starts clean
  assign half_tick = run && !restart && (cnt_q == CNT_LAST);
  assign bit_tick  = half_tick && phase_q;
  assign phase     = phase_q;

  // Next counter and half-phase: wrap the counter and flip the phase at each half-bit end
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/manchester_tx.sv
// rtl/manchester_tx.sv - framed Manchester line encoder; MANCHESTER_TX_PARITY_EN adds an even parity bit
module manchester_tx
  import manchester_pkg::*;
#(
  parameter int HALF_PRD = 8,
  parameter int DATA_W   = 8,
  parameter int PRE_BITS = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              man,
  output logic              busy
);

  localparam int BW = $clog2(max3(PRE_BITS, DATA_W, GAP_BITS) + 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_BITS - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              man_q, man_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
`ifdef MANCHESTER_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic accept;
  logic half_tick;
  logic bit_tick;
  logic phase_q;
  logic phase_d;

  assign accept  = din_vld && rdy_q;
  assign din_rdy = rdy_q;
  assign man     = man_q;
  assign busy    = busy_q;

  man_bit_timer #(
    .HALF_PRD (HALF_PRD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart   (accept),
    .run       (busy_q),
    .half_tick (half_tick),
    .bit_tick  (bit_tick),
    .phase     (phase_q)
  );

  // Half-phase the timer will hold next cycle, so the line level is registered in step with it
  assign phase_d = accept ? 1'b0 : (phase_q ^ half_tick);

  // Frame sequencing: advance one bit per completed bit cell, move between sections on the last bit
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    rdy_d     = rdy_q;
`ifdef MANCHESTER_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          state_d   = ST_PRE;
          bit_cnt_d = '0;
          shift_d   = din;
          busy_d    = 1'b1;
          rdy_d     = 1'b0;
`ifdef MANCHESTER_TX_PARITY_EN
          par_d     = even_parity(PARITY_MAX_W'(din));
`endif
        end
      end
      ST_PRE: begin
        if (bit_tick) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q << 1;
          if (bit_cnt_q == DATA_LAST) begin
`ifdef MANCHESTER_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_GAP;
`endif
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef MANCHESTER_TX_PARITY_EN
      ST_PAR: begin
        if (bit_tick) begin
          state_d   = ST_GAP;
          bit_cnt_d = '0;
        end
      end
`endif
      ST_GAP: begin
        if (bit_tick) begin
          if (bit_cnt_q == GAP_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            rdy_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
        rdy_d     = 1'b0;
      end
    endcase
  end

  // Line level for the coming cycle, taken from where the frame will be after this edge
  always_comb begin
    man_d = MAN_IDLE;
    case (state_d)
      ST_PRE:  man_d = half_level(~bit_cnt_d[0], phase_d);
      ST_DATA: man_d = half_level(shift_d[DATA_W-1], phase_d);
`ifdef MANCHESTER_TX_PARITY_EN
      ST_PAR:  man_d = half_level(par_q, phase_d);
`endif
      default: man_d = MAN_IDLE;
    endcase
  end

  // State, data path and registered outputs; reset drops the line immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      man_q     <= MAN_IDLE;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef MANCHESTER_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      man_q     <= man_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
`ifdef MANCHESTER_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// tb/tb_manchester_tx.sv - self-checking bench for manchester_tx
module tb_manchester_tx;

  localparam int H  = 4;
  localparam int DW = 8;
  localparam int PB = 4;
  localparam int GB = 2;
`ifdef MANCHESTER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FEND = (PB + DW + PAR) * 2 * H;
  localparam int TOT  = FEND + GB * 2 * H;

  typedef struct {
    int   cyc;
    logic m;
    logic b;
    logic r;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic          man;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic exp_w    [1:TOT];
  logic cap_man  [0:TOT+1];
  logic cap_busy [0:TOT+1];
  logic cap_rdy  [0:TOT+1];
  vec_t tbl[$];

  manchester_tx #(
    .HALF_PRD (H),
    .DATA_W   (DW),
    .PRE_BITS (PB),
    .GAP_BITS (GB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .man     (man),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line waveform for one frame: list the bits, then expand each to two half-bits
  task automatic model_frame(input logic [DW-1:0] w);
    logic bits[$];
    bits = {};
    for (int k = 0; k < PB; k++) bits.push_back((k % 2) == 0);
    for (int j = DW - 1; j >= 0; j--) bits.push_back(w[j]);
    if (PAR == 1) bits.push_back(($countones(w) % 2) == 1);
    for (int c = 1; c <= TOT; c++) exp_w[c] = 1'b0;
    for (int i = 0; i < bits.size(); i++) begin
      for (int t = 0; t < 2 * H; t++) begin
        exp_w[1 + i * 2 * H + t] = (t < H) ? ~bits[i] : bits[i];
      end
    end
  endtask

  // Idle for 'idle' cycles, offer w, then follow the frame through its gap
  task automatic send_frame(input logic [DW-1:0] w, input int idle, input bit noise, input bit hold);
    int man_bad;
    int flag_bad;
    model_frame(w);
    for (int i = 0; i <= idle; i++) begin
      @(negedge clk);
      chk("idle_outputs", {29'd0, man, busy, din_rdy}, 32'b001);
      if (i == idle) begin
        din     = w;
        din_vld = 1'b1;
      end else begin
        din     = DW'($urandom);
        din_vld = 1'b0;
      end
    end
    cap_man[0] = man; cap_busy[0] = busy; cap_rdy[0] = din_rdy;
    man_bad  = 0;
    flag_bad = 0;
    for (int c = 1; c <= TOT; c++) begin
      @(negedge clk);
      cap_man[c] = man; cap_busy[c] = busy; cap_rdy[c] = din_rdy;
      if (man !== exp_w[c] && man_bad == 0) man_bad = c;
      if ({busy, din_rdy} !== 2'b10 && flag_bad == 0) flag_bad = c;
      din     = DW'($urandom);
      din_vld = hold ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0);
    end
    chk($sformatf("man_wave_%02h_first_bad_cycle", w), man_bad, 0);
    chk($sformatf("busy_rdy_%02h_first_bad_cycle", w), flag_bad, 0);
  endtask

  initial begin
    int quiet_bad;
    logic [DW-1:0] w;

    tbl.push_back('{1,      1'b0, 1'b1, 1'b0});
    tbl.push_back('{4,      1'b0, 1'b1, 1'b0});
    tbl.push_back('{5,      1'b1, 1'b1, 1'b0});
    tbl.push_back('{8,      1'b1, 1'b1, 1'b0});
    tbl.push_back('{9,      1'b1, 1'b1, 1'b0});
    tbl.push_back('{13,     1'b0, 1'b1, 1'b0});
    tbl.push_back('{32,     1'b0, 1'b1, 1'b0});
    tbl.push_back('{33,     1'b0, 1'b1, 1'b0});
    tbl.push_back('{36,     1'b0, 1'b1, 1'b0});
    tbl.push_back('{37,     1'b1, 1'b1, 1'b0});
    tbl.push_back('{40,     1'b1, 1'b1, 1'b0});
    tbl.push_back('{41,     1'b1, 1'b1, 1'b0});
    tbl.push_back('{45,     1'b0, 1'b1, 1'b0});
    tbl.push_back('{96,     1'b1, 1'b1, 1'b0});
    tbl.push_back('{FEND+1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{TOT,    1'b0, 1'b1, 1'b0});
    tbl.push_back('{TOT+1,  1'b0, 1'b0, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {29'd0, man, busy, din_rdy}, 32'b000);
    rst = 1'b0;
    #1;
    chk("rdy_before_first_edge", {31'd0, din_rdy}, 32'd0);
    @(negedge clk);
    chk("rdy_after_release", {29'd0, man, busy, din_rdy}, 32'b001);

    // Reference frame 8'hA5 against hand-derived vectors
    send_frame(8'hA5, 0, 1'b0, 1'b0);
    @(negedge clk);
    cap_man[TOT+1] = man; cap_busy[TOT+1] = busy; cap_rdy[TOT+1] = din_rdy;
    din_vld = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc),
          {29'd0, cap_man[tbl[i].cyc], cap_busy[tbl[i].cyc], cap_rdy[tbl[i].cyc]},
          {29'd0, tbl[i].m, tbl[i].b, tbl[i].r});
    end

`ifdef MANCHESTER_TX_PARITY_EN
    // Parity bit of 8'h07 is 1: low then high, gap afterwards
    send_frame(8'h07, 1, 1'b0, 1'b0);
    chk("par_low_c97",  {31'd0, cap_man[97]},  32'd0);
    chk("par_low_c100", {31'd0, cap_man[100]}, 32'd0);
    chk("par_high_c101", {31'd0, cap_man[101]}, 32'd1);
    chk("par_high_c104", {31'd0, cap_man[104]}, 32'd1);
    chk("par_gap_c105", {30'd0, cap_man[105], cap_busy[105]}, 32'b01);
    chk("par_gap_c120", {30'd0, cap_man[120], cap_busy[120]}, 32'b01);
`endif

    // Back-to-back with din_vld held high; din noise while busy must be ignored
    send_frame(8'hFF, 1, 1'b0, 1'b1);
    send_frame(8'h00, 0, 1'b0, 1'b1);
    send_frame(8'h3C, 0, 1'b0, 1'b0);

    // Randomised words, idle spacing and handshake noise while busy
    for (int n = 0; n < 20; n++) begin
      w = DW'($urandom);
      send_frame(w, $urandom_range(0, 3), 1'b1, 1'b0);
    end

    // Reset mid-data truncates the frame at once
    @(negedge clk);
    din_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_idle", {29'd0, man, busy, din_rdy}, 32'b001);
    din     = 8'hA5;
    din_vld = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      @(negedge clk);
      din_vld = 1'b0;
    end
    chk("pre_rst_c54", {30'd0, man, busy}, 32'b11);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {29'd0, man, busy, din_rdy}, 32'b000);
    quiet_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({man, busy, din_rdy} !== 3'b000) quiet_bad++;
    end
    chk("rst_held_outputs", quiet_bad, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_rdy_low", {31'd0, din_rdy}, 32'd0);
    @(negedge clk);
    chk("rst_release_rdy_high", {29'd0, man, busy, din_rdy}, 32'b001);
    quiet_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({man, busy} !== 2'b00) quiet_bad++;
    end
    chk("no_residual_edges", quiet_bad, 0);

    // Encoder still works after the truncated frame
    send_frame(8'h5A, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/manchester_tx.md
# manchester_tx

Manchester line encoder, the transmit end of the link whose receiver recovers period and bit enable from `man` edges. It accepts parallel words over a valid/ready handshake and emits a framed, self-clocking serial line: an alternating preamble, data MSB-first, an optional parity bit, then an idle gap. The preamble gives the far-end period estimator a clean, regular edge train before data begins.

## Interface
- `HALF_PRD`, 8: clocks per half-bit, ≥2; one bit time = 2*HALF_PRD clocks.
- `DATA_W`, 8: data bits per frame, ≥1.
- `PRE_BITS`, 8: preamble bits per frame, ≥2, pattern 1010… starting with 1.
- `GAP_BITS`, 2: idle bit times after each frame, ≥1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  DATA_W  word to send; sampled on accept.
- `din_vld`  in  1  `din` valid.
- `din_rdy`  out  1  encoder ready; accept = `din_vld && din_rdy`.
- `man`  out  1  Manchester line, registered.
- `busy`  out  1  high from first preamble half-bit through last gap cycle.

## Operation
- Encoding (IEEE 802.3): bit 1 = low half then high half; bit 0 = high half then low half. Idle line level 0.
- FSM states: IDLE, PRE, DATA, PAR (only with parity), GAP.
- IDLE: `man`=0, `busy`=0, `din_rdy`=1. On accept, latch `din` into shift register, clear counters, go to PRE.
- PRE: PRE_BITS bits, bit k = ~k[0] (1,0,1,0,…). Then DATA.
- DATA: DATA_W bits, MSB first, shift left per bit. Then PAR if enabled, else GAP.
- PAR: one bit, even parity (XOR of latched word). Then GAP.
- GAP: `man`=0 for GAP_BITS*2*HALF_PRD clocks, `busy`=1, `din_rdy`=0. Then IDLE.
- Half-bit counter 0..HALF_PRD-1 (width $clog2(HALF_PRD), min 1); half-phase flag toggles on wrap; bit counter advances when the second half wraps. Bit counter width $clog2(max(PRE_BITS, DATA_W, GAP_BITS)+1).
- `din_vld`/`din` changes while `din_rdy`=0 are ignored; no word is lost or duplicated. `din_vld` held high continuously produces back-to-back frames separated by exactly the gap.
- Reset: asynchronous and immediate. `man`=0, `busy`=0, `din_rdy`=0, state IDLE, counters and shift register cleared. Reset mid-frame truncates the frame with no further edges. `din_rdy` rises on the first clock edge after `rst` deasserts.

## Timing
- Accept at edge 0. `man` carries first preamble half-bit from cycle 1; `busy` rises at cycle 1.
- Each half-bit lasts exactly HALF_PRD cycles; no jitter and no stretch at state boundaries.
- Frame (no parity) occupies cycles 1..(PRE_BITS+DATA_W)*2*HALF_PRD. Gap follows immediately.
- `busy` falls and `din_rdy` rises on the same edge, the cycle after the last gap cycle. Next accept is possible on that cycle; that frame's `man` starts one cycle later.
- `din_rdy` is low during the accept cycle's following edge onward (single-cycle accept).

## Configuration
- `MANCHESTER_TX_PARITY_EN` defined: PAR state present; frame carries DATA_W+1 payload bits, the last being even parity.
- Undefined: no PAR state or parity logic; DATA goes straight to GAP.

## Structure
- `manchester_pkg`: state enum (IDLE, PRE, DATA, PAR, GAP), line-level constants (`MAN_IDLE`=0, half-bit levels for 0/1), parity function.
- Sub-module `man_bit_timer`: half-bit counter with `half_tick` and `bit_tick` outputs, restart input, and parameter HALF_PRD. The FSM and shifter stay in `manchester_tx`.

## Test plan
- HALF_PRD=4, PRE_BITS=4, GAP_BITS=2, parity off; send `din`=8'hA5 at cycle 0.
  - Expected: `man` = 0×4,1×4 / 1×4,0×4 repeated for preamble (cycles 1–32).
  - Data bit 7 shows 0 on cycles 33–36 and 1 on 37–40.
  - Frame ends at cycle 96, `man`=0 on cycles 97–112, `din_rdy`=1 at cycle 113.
- Same settings, `din_vld` held high with 8'hFF then 8'h00: second frame's `man` begins at cycle 114. Words stay in order with no loss, and `din` changes during `busy` have no effect.
- Parity on, `din`=8'h07 (three ones): parity bit 1 is sent as low/high on cycles 97–104; gap runs 105–120.
- Assert `rst` at cycle 50 mid-data: `man`=0 and `busy`=0 immediately, `din_rdy`=0 during reset, `din_rdy`=1 one edge after release, and no residual edges.
- Loopback into the existing receiver with HALF_PRD=8: after the preamble, recovered `en`/`sys` align to bit centres and the decoded word equals the sent word for 256 random words.
